// File: rtl/present_pkg.sv
// Shared PRESENT constants and types; PRESENT_KEY128_EN selects the 128-bit key variant.
package present_pkg;

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
`else
  localparam int KEY_W = 80;
`endif

  localparam int RK_W   = 64;
  localparam int NUM_RK = 32;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic {IDLE, RUN} ks_state_t;

endpackage

// File: rtl/present_key_schedule_if.sv
// Round-key handshake bundle between the round controller (master) and the key schedule (slave).
interface present_key_schedule_if;
  import present_pkg::*;

  logic             load_i;
  logic [KEY_W-1:0] key_i;
  logic [RK_W-1:0]  rk_o;
  logic             rk_valid_o;
  logic             rk_ready_i;
  logic [4:0]       rk_idx_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output load_i, key_i, rk_ready_i,
    input  rk_o, rk_valid_o, rk_idx_o, busy_o, done_o
  );

  modport slave (
    input  load_i, key_i, rk_ready_i,
    output rk_o, rk_valid_o, rk_idx_o, busy_o, done_o
  );

endinterface

// File: rtl/present_sbox4.sv
// Combinational 4-bit PRESENT S-box, shared by the key schedule and the sbox layer.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/present_key_schedule.sv
// Iterative PRESENT round-key generator issuing K1..K32 over valid/ready after a load.
// Build with PRESENT_KEY128_EN for the 128-bit key schedule; default is the 80-bit one.
module present_key_schedule
  import present_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  present_key_schedule_if.slave ks
);

  ks_state_t        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] key_rot, key_upd;
  logic [4:0]       rc_q, rc_d;
  logic [4:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             xfer;
  logic [3:0]       sb_hi_out;

  // Rotate left by 61 bits.
  assign key_rot = {key_q[KEY_W-62:0], key_q[KEY_W-1:KEY_W-61]};

  present_sbox4 u_sbox_hi (.din(key_rot[KEY_W-1 -: 4]), .dout(sb_hi_out));

`ifdef PRESENT_KEY128_EN
  logic [3:0] sb_lo_out;

  present_sbox4 u_sbox_lo (.din(key_rot[KEY_W-5 -: 4]), .dout(sb_lo_out));

  always_comb begin
    key_upd          = key_rot;
    key_upd[127:124] = sb_hi_out;
    key_upd[123:120] = sb_lo_out;
    key_upd[66:62]   = key_rot[66:62] ^ rc_q;
  end
`else
  always_comb begin
    key_upd        = key_rot;
    key_upd[79:76] = sb_hi_out;
    key_upd[19:15] = key_rot[19:15] ^ rc_q;
  end
`endif

  assign xfer = (state_q == RUN) && ks.rk_ready_i;

  // A load always wins, including over a simultaneous final transfer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (ks.load_i) begin
      state_d = RUN;
      key_d   = ks.key_i;
      rc_d    = 5'd1;
      idx_d   = 5'd0;
    end else if (xfer) begin
      if (idx_q == 5'(NUM_RK - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        key_d = key_upd;
        rc_d  = rc_q + 5'd1;
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      rc_q    <= 5'd1;
      idx_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign ks.rk_o       = key_q[KEY_W-1 -: RK_W];
  assign ks.rk_valid_o = (state_q == RUN);
  assign ks.busy_o     = (state_q == RUN);
  assign ks.rk_idx_o   = idx_q;
  assign ks.done_o     = done_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// Scoreboard bench for present_key_schedule: stimulus queues expected transfers, a negedge monitor checks them.
module tb_present_key_schedule;
  import present_pkg::*;

  typedef struct {
    bit          is_done;
    logic [4:0]  idx;
    logic [63:0] rk;
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  present_key_schedule_if ks_if();

  present_key_schedule dut (
    .clk_i (clk),
    .rst_i (rst),
    .ks    (ks_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ref_sbox [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [KEY_W-1:0] KEY_A = {(KEY_W/8){8'h5A}};
  localparam logic [KEY_W-1:0] KEY_B = {64'h0123456789ABCDEF, {(KEY_W-64){1'b1}}};

`ifdef PRESENT_KEY128_EN
  localparam logic [63:0] K2_ZERO = 64'hCC00000000000000;
  localparam logic [63:0] K3_ZERO = 64'hC300000000000000;
  localparam logic [63:0] K4_ZERO = 64'h5B30000000000000;
`else
  localparam logic [63:0] K2_ZERO = 64'hC000000000000000;
  localparam logic [63:0] K3_ZERO = 64'h5000180000000001;
  localparam logic [63:0] K4_ZERO = 64'h60000A0003000001;
`endif

  logic [KEY_W-1:0] mk;
  logic [4:0]       mrc;
  logic [4:0]       midx;

  function automatic logic [KEY_W-1:0] ref_upd(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = (k << 61) | (k >> (KEY_W - 61));
`ifdef PRESENT_KEY128_EN
    r[127:124] = ref_sbox[r[127:124]];
    r[123:120] = ref_sbox[r[123:120]];
    r[66:62]   = r[66:62] ^ rc;
`else
    r[79:76] = ref_sbox[r[79:76]];
    r[19:15] = r[19:15] ^ rc;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per observed transfer or done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ks_if.done_o) begin
        n_tests++;
        if (sb_q.size() == 0 || !sb_q[0].is_done) begin
          n_fail++;
          $display("FAIL done_pulse: got done_o=1, required done_o=0");
        end else begin
          e = sb_q.pop_front();
        end
      end
      if (!rst && ks_if.rk_valid_o && ks_if.rk_ready_i) begin
        if (sb_q.size() == 0 || sb_q[0].is_done) begin
          n_tests++;
          n_fail++;
          $display("FAIL xfer_unexpected: got transfer idx %0d rk %h, required none", ks_if.rk_idx_o, ks_if.rk_o);
        end else begin
          e = sb_q.pop_front();
          chk("xfer_idx", 64'(ks_if.rk_idx_o), 64'(e.idx));
          chk("xfer_rk", ks_if.rk_o, e.rk);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer();
    exp_t e;
    e.is_done = 1'b0;
    e.idx     = midx;
    e.rk      = mk[KEY_W-1 -: 64];
    sb_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.idx     = 5'd0;
    e.rk      = 64'd0;
    sb_q.push_back(e);
  endtask

  task automatic xfer_one();
    ks_if.rk_ready_i = 1'b1;
    push_xfer();
    tick();
    if (midx == 5'd31) begin
      push_done();
    end else begin
      mk   = ref_upd(mk, mrc);
      mrc  = mrc + 5'd1;
      midx = midx + 5'd1;
    end
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k);
    ks_if.rk_ready_i = 1'b0;
    ks_if.load_i     = 1'b1;
    ks_if.key_i      = k;
    tick();
    ks_if.load_i = 1'b0;
    mk   = k;
    mrc  = 5'd1;
    midx = 5'd0;
  endtask

  // Load plus a simultaneous transfer: the transfer is seen but discarded.
  task automatic load_with_xfer(input logic [KEY_W-1:0] k);
    push_xfer();
    ks_if.rk_ready_i = 1'b1;
    ks_if.load_i     = 1'b1;
    ks_if.key_i      = k;
    tick();
    ks_if.load_i     = 1'b0;
    ks_if.rk_ready_i = 1'b0;
    mk   = k;
    mrc  = 5'd1;
    midx = 5'd0;
  endtask

  task automatic finish_run(input bit random_stall);
    int n;
    n = 32 - int'(midx);
    for (int i = 0; i < n; i++) begin
      if (random_stall && $urandom_range(0, 1) == 1) begin
        ks_if.rk_ready_i = 1'b0;
        tick();
      end
      xfer_one();
    end
    ks_if.rk_ready_i = 1'b0;
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    ks_if.load_i     = 1'b0;
    ks_if.key_i      = '0;
    ks_if.rk_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", 64'(ks_if.rk_valid_o), 64'd0);
    chk("rst_busy", 64'(ks_if.busy_o), 64'd0);
    chk("rst_done", 64'(ks_if.done_o), 64'd0);
    chk("rst_idx", 64'(ks_if.rk_idx_o), 64'd0);
    chk("rst_rk", ks_if.rk_o, 64'd0);

    // Zero key, ready held high.
    load_key('0);
    chk("k1_valid", 64'(ks_if.rk_valid_o), 64'd1);
    chk("k1_busy", 64'(ks_if.busy_o), 64'd1);
    chk("k1_rk", ks_if.rk_o, 64'd0);
    xfer_one();
    chk("k2_rk", ks_if.rk_o, K2_ZERO);
    xfer_one();
    chk("k3_rk", ks_if.rk_o, K3_ZERO);
    xfer_one();
    chk("k4_rk", ks_if.rk_o, K4_ZERO);
    chk("k4_idx", 64'(ks_if.rk_idx_o), 64'd3);
    repeat (28) xfer_one();
    chk("pre_last_idx", 64'(ks_if.rk_idx_o), 64'd31);
    xfer_one();
    chk("last_done", 64'(ks_if.done_o), 64'd1);
    chk("last_busy", 64'(ks_if.busy_o), 64'd0);
    chk("last_valid", 64'(ks_if.rk_valid_o), 64'd0);
    ks_if.rk_ready_i = 1'b0;
    tick();
    chk("done_one_cycle", 64'(ks_if.done_o), 64'd0);

    // Backpressure at idx 5, then random stalls.
    load_key(KEY_A);
    repeat (5) xfer_one();
    ks_if.rk_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_idx", 64'(ks_if.rk_idx_o), 64'd5);
      chk("stall_rk", ks_if.rk_o, mk[KEY_W-1 -: 64]);
      chk("stall_valid", 64'(ks_if.rk_valid_o), 64'd1);
    end
    finish_run(1'b1);

    // Abort after 10 keys with a new load and ready high.
    load_key(KEY_A);
    repeat (10) xfer_one();
    load_with_xfer(KEY_B);
    chk("abort_idx", 64'(ks_if.rk_idx_o), 64'd0);
    chk("abort_rk", ks_if.rk_o, 64'h0123456789ABCDEF);
    chk("abort_done", 64'(ks_if.done_o), 64'd0);
    finish_run(1'b0);

    // Reset at idx 17 overrides a concurrent load.
    load_key(KEY_B);
    repeat (17) xfer_one();
    ks_if.rk_ready_i = 1'b0;
    rst              = 1'b1;
    ks_if.load_i     = 1'b1;
    ks_if.key_i      = KEY_A;
    tick();
    rst          = 1'b0;
    ks_if.load_i = 1'b0;
    chk("mrst_valid", 64'(ks_if.rk_valid_o), 64'd0);
    chk("mrst_busy", 64'(ks_if.busy_o), 64'd0);
    chk("mrst_rk", ks_if.rk_o, 64'd0);
    chk("mrst_idx", 64'(ks_if.rk_idx_o), 64'd0);
    load_key(KEY_B);
    chk("reload_rk", ks_if.rk_o, 64'h0123456789ABCDEF);
    finish_run(1'b1);

    // Load coinciding with the 32nd transfer.
    load_key(KEY_A);
    repeat (31) xfer_one();
    load_with_xfer(KEY_B);
    chk("lastload_done", 64'(ks_if.done_o), 64'd0);
    chk("lastload_busy", 64'(ks_if.busy_o), 64'd1);
    chk("lastload_idx", 64'(ks_if.rk_idx_o), 64'd0);
    chk("lastload_rk", ks_if.rk_o, 64'h0123456789ABCDEF);
    finish_run(1'b0);

    // Ready in IDLE has no effect.
    ks_if.rk_ready_i = 1'b1;
    tick();
    tick();
    chk("idle_ready_valid", 64'(ks_if.rk_valid_o), 64'd0);
    chk("idle_ready_done", 64'(ks_if.done_o), 64'd0);
    ks_if.rk_ready_i = 1'b0;
    tick();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
